rsa_mont_arbiter: RTL and testbench

RSA_MONT_ARBITER -- requirements
Module: rsa_mont_arbiter

---
 rtl/RSA_pkg.sv | 29 ++
 rtl/rsa_rr_arbiter.sv | 32 +++
 rtl/rsa_mont_arbiter.sv | 109 ++++++++++
 tb/tb_rsa_mont_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/RSA_pkg.sv
// Shared RSA datapath types: Montgomery multiplier operand/result structs and
// the state encoding of the multiplier-sharing arbiter.
package RSA_pkg;

  localparam int RSA_W = 256;

  typedef struct packed {
    logic [RSA_W-1:0] a;
    logic [RSA_W-1:0] b;
    logic [RSA_W-1:0] modulus;
  } RSAMontgomeryModIn;

  typedef struct packed {
    logic [RSA_W-1:0] result;
  } RSAMontgomeryModOut;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } RSAMontArbState;

  // Width of a requester index; never zero so NREQ=1 still has a legal vector.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rsa_rr_arbiter
  import RSA_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW = ptrWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grantIdx,
  output logic            anyReq
);

  always_comb begin
    logic [PW-1:0] idx;
    grant    = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    idx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr) + off) % NREQ);
      if (!anyReq && req[idx]) begin
        anyReq      = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

endmodule

// File: rtl/rsa_mont_arbiter.sv
// Shares one Montgomery multiplier among NREQ requesters: round-robin grant,
// single outstanding operation, result returned to the granted requester only.
module rsa_mont_arbiter
  import RSA_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic               [NREQ-1:0]      req_valid,
  output logic               [NREQ-1:0]      req_ready,
  input  RSAMontgomeryModIn  [NREQ-1:0]      req_data,
  output logic               [NREQ-1:0]      rsp_valid,
  input  logic               [NREQ-1:0]      rsp_ready,
  output RSAMontgomeryModOut                 rsp_data,
  output logic                               mont_i_valid,
  input  logic                               mont_i_ready,
  output RSAMontgomeryModIn                  mont_i_in,
  input  logic                               mont_o_valid,
  output logic                               mont_o_ready,
  input  RSAMontgomeryModOut                 mont_o_out,
  output logic                               busy
);

  localparam int PW = ptrWidth(NREQ);

  RSAMontArbState     state;
  RSAMontArbState     nextState;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  RSAMontgomeryModIn  opReg;
  RSAMontgomeryModOut resReg;

  logic [NREQ-1:0]    grant;
  logic [PW-1:0]      grantIdx;
  logic               anyReq;
  logic               take;

  function automatic logic [PW-1:0] incWrap(input logic [PW-1:0] i);
    if (int'(i) >= NREQ - 1) return '0;
    return i + PW'(1);
  endfunction

  rsa_rr_arbiter #(
    .NREQ(NREQ)
  ) uArb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .grantIdx(grantIdx),
    .anyReq  (anyReq)
  );

  always_comb begin
    nextState    = state;
    req_ready    = '0;
    rsp_valid    = '0;
    mont_i_valid = 1'b0;
    mont_o_ready = 1'b0;
    take         = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset is asserted, since the
        // state register already reads IDLE then.
        if (rst_n && anyReq) begin
          req_ready = grant;
          take      = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        mont_i_valid = 1'b1;
        if (mont_i_ready) nextState = WAIT;
      end
      WAIT: begin
        mont_o_ready = 1'b1;
        if (mont_o_valid) nextState = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      opReg  <= '0;
      resReg <= '0;
    end else begin
      state <= nextState;
      if (take) begin
        opReg <= req_data[grantIdx];
        owner <= grantIdx;
        ptr   <= incWrap(grantIdx);
      end
      if (state == WAIT && mont_o_valid) resReg <= mont_o_out;
    end
  end

  assign mont_i_in = opReg;
  assign rsp_data  = resReg;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Directed bench for rsa_mont_arbiter with an a+b stub multiplier of fixed latency.
module tb_rsa_mont_arbiter;
  import RSA_pkg::*;

  localparam int NREQ = 2;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic              [NREQ-1:0]      req_valid;
  logic              [NREQ-1:0]      req_ready;
  RSAMontgomeryModIn [NREQ-1:0]      req_data;
  logic              [NREQ-1:0]      rsp_valid;
  logic              [NREQ-1:0]      rsp_ready;
  RSAMontgomeryModOut                rsp_data;
  logic                              mont_i_valid;
  logic                              mont_i_ready;
  RSAMontgomeryModIn                 mont_i_in;
  logic                              mont_o_valid;
  logic                              mont_o_ready;
  RSAMontgomeryModOut                mont_o_out;
  logic                              busy;

  always #5 clk = ~clk;

  rsa_mont_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .mont_i_valid(mont_i_valid),
    .mont_i_ready(mont_i_ready),
    .mont_i_in   (mont_i_in),
    .mont_o_valid(mont_o_valid),
    .mont_o_ready(mont_o_ready),
    .mont_o_out  (mont_o_out),
    .busy        (busy)
  );

  // Stub multiplier: result = a+b, valid 4 cycles after the operand handshake.
  logic         miReady = 1'b1;
  logic         forceOValid = 1'b0;
  logic         stubPend;
  logic [2:0]   stubCnt;
  logic [255:0] stubRes;

  assign mont_i_ready = miReady && !stubPend;
  assign mont_o_valid = (stubPend && stubCnt == 3'd0) || forceOValid;
  assign mont_o_out   = stubRes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stubPend <= 1'b0;
      stubCnt  <= 3'd0;
      stubRes  <= '0;
    end else if (mont_i_valid && mont_i_ready) begin
      stubPend <= 1'b1;
      stubCnt  <= 3'd4;
      stubRes  <= mont_i_in.a + mont_i_in.b;
    end else if (stubPend && stubCnt != 3'd0) begin
      stubCnt <= stubCnt - 3'd1;
    end else if (stubPend && mont_o_ready) begin
      stubPend <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic waitGrant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitRsp(output int lat, output bit busyAll);
    lat = 0;
    busyAll = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != '0) break;
      if (!busy) busyAll = 1'b0;
    end
  endtask

  task automatic serve(input int idx, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] exp, input string tag);
    bit ok;
    int lat;
    bit busyAll;
    req_data[idx].a = a;
    req_data[idx].b = b;
    req_data[idx].modulus = '0;
    req_valid[idx] = 1'b1;
    waitGrant(ok);
    chk({tag, " grant"}, 768'(req_ready), 768'(2'b01 << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    waitRsp(lat, busyAll);
    chk({tag, " latency"}, 768'(lat), 768'(7));
    chk({tag, " busy"}, 768'(busyAll), 768'(1));
    chk({tag, " rsp_valid"}, 768'(rsp_valid), 768'(2'b01 << idx));
    chk({tag, " rsp_data"}, 768'(rsp_data.result), 768'(exp));
    @(posedge clk); #1;
  endtask

  typedef struct {
    int           idx;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int lat;
    bit busyAll;
    logic [255:0] one;
    logic [255:0] top;
    RSAMontgomeryModIn expIn;

    one = 256'd1;
    top = one << 255;
    vecs[0] = '{0, 256'd3, 256'd5, 256'd8};
    vecs[1] = '{1, 256'd10, 256'd20, 256'd30};
    vecs[2] = '{0, '1, 256'd2, 256'd1};
    vecs[3] = '{1, top, top, 256'd0};

    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_data = '0;
    req_data[0].a = 256'd9;
    #1;
    chk("rst req_ready", 768'(req_ready), 768'(0));
    chk("rst rsp_valid", 768'(rsp_valid), 768'(0));
    chk("rst rsp_data", 768'(rsp_data), 768'(0));
    chk("rst mont_i_valid", 768'(mont_i_valid), 768'(0));
    chk("rst mont_i_in", 768'(mont_i_in), 768'(0));
    chk("rst mont_o_ready", 768'(mont_o_ready), 768'(0));
    chk("rst busy", 768'(busy), 768'(0));
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      serve(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Contention from reset release: alternating grants 0,1,0,1.
    rst_n = 1'b0;
    req_data[0].a = 256'd1;  req_data[0].b = 256'd2;
    req_data[1].a = 256'd10; req_data[1].b = 256'd20;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitGrant(ok);
      chk($sformatf("contend grant%0d", i), 768'(req_ready), 768'((i % 2 == 0) ? 2'b01 : 2'b10));
      waitRsp(lat, busyAll);
      chk($sformatf("contend rsp_valid%0d", i), 768'(rsp_valid), 768'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk($sformatf("contend rsp_data%0d", i), 768'(rsp_data.result), 768'((i % 2 == 0) ? 3 : 30));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Response backpressure on requester 0 while requester 1 keeps asking.
    rsp_ready = 2'b10;
    req_data[0].a = 256'd7; req_data[0].b = 256'd9;
    req_data[1].a = 256'd4; req_data[1].b = 256'd4;
    req_valid = 2'b11;
    waitGrant(ok);
    chk("bp grant0", 768'(req_ready), 768'(2'b01));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitRsp(lat, busyAll);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp rsp_valid c%0d", i), 768'(rsp_valid), 768'(2'b01));
      chk($sformatf("bp rsp_data c%0d", i), 768'(rsp_data.result), 768'(16));
      chk($sformatf("bp req_ready c%0d", i), 768'(req_ready), 768'(0));
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", 768'(rsp_valid), 768'(2'b01));
    @(negedge clk);
    chk("bp idle busy", 768'(busy), 768'(0));
    chk("bp grant1", 768'(req_ready), 768'(2'b10));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    waitRsp(lat, busyAll);
    chk("bp rsp1 valid", 768'(rsp_valid), 768'(2'b10));
    chk("bp rsp1 data", 768'(rsp_data.result), 768'(8));
    @(posedge clk); #1;

    // Multiplier operand stall.
    miReady = 1'b0;
    req_data[0].a = 256'd100; req_data[0].b = 256'd23; req_data[0].modulus = 256'd77;
    expIn = req_data[0];
    req_valid[0] = 1'b1;
    waitGrant(ok);
    chk("stall grant", 768'(req_ready), 768'(2'b01));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_data[0] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall mont_i_valid c%0d", i), 768'(mont_i_valid), 768'(1));
      chk($sformatf("stall mont_i_in c%0d", i), mont_i_in, expIn);
      @(posedge clk); #1;
    end
    miReady = 1'b1;
    waitRsp(lat, busyAll);
    chk("stall rsp_valid", 768'(rsp_valid), 768'(2'b01));
    chk("stall rsp_data", 768'(rsp_data.result), 768'(123));
    @(posedge clk); #1;

    // Reset while the multiplier is working.
    req_data[0].a = 256'd5; req_data[0].b = 256'd6;
    req_valid[0] = 1'b1;
    waitGrant(ok);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wait state mont_o_ready", 768'(mont_o_ready), 768'(1));
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("midrst req_ready", 768'(req_ready), 768'(0));
    chk("midrst rsp_valid", 768'(rsp_valid), 768'(0));
    chk("midrst rsp_data", 768'(rsp_data), 768'(0));
    chk("midrst mont_i_valid", 768'(mont_i_valid), 768'(0));
    chk("midrst mont_i_in", 768'(mont_i_in), 768'(0));
    chk("midrst mont_o_ready", 768'(mont_o_ready), 768'(0));
    chk("midrst busy", 768'(busy), 768'(0));
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    forceOValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("stale busy c%0d", i), 768'(busy), 768'(0));
      chk($sformatf("stale mont_o_ready c%0d", i), 768'(mont_o_ready), 768'(0));
      chk($sformatf("stale rsp_valid c%0d", i), 768'(rsp_valid), 768'(0));
      @(posedge clk); #1;
    end
    forceOValid = 1'b0;
    serve(1, 256'd1, 256'd1, 256'd2, "postrst");

    // Pointer wrapped back to 0 after serving requester 1.
    req_data[0].a = 256'd40; req_data[0].b = 256'd2;
    req_data[1].a = 256'd50; req_data[1].b = 256'd3;
    req_valid = 2'b11;
    waitGrant(ok);
    chk("wrap grant", 768'(req_ready), 768'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitRsp(lat, busyAll);
    chk("wrap rsp_valid", 768'(rsp_valid), 768'(2'b01));
    chk("wrap rsp_data", 768'(rsp_data.result), 768'(42));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
